// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, branch conditions and the architectural flag layout.
// Used by the result stage and the branch unit.
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RA_W_DEF   = 3;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    CMP = 4'd5,
    MOV = 4'd6,
    SLL = 4'd8,
    SLR = 4'd9,
    SRL = 4'd10,
    SRA = 4'd11,
    LD  = 4'd12,
    ST  = 4'd15
  } alu_op_t;

  typedef enum logic [2:0] {
    BE     = 3'd0,
    BLT    = 3'd1,
    BLE    = 3'd2,
    BNE    = 3'd3,
    ALWAYS = 3'd4
  } br_cond_t;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition decode against a flag set.
// Shared with the branch unit; unused condition codes never take.
module br_cond_eval
  import alu_pkg::*;
(
  input  flags_t   flags,
  input  br_cond_t cond,
  output logic     taken
);

  // decode the condition code into a taken decision
  always_comb begin
    taken = 1'b0;
    case (cond)
      BE:      taken = flags.z;
      BLT:     taken = flags.s ^ flags.v;
      BLE:     taken = flags.z | (flags.s ^ flags.v);
      BNE:     taken = ~flags.z;
      ALWAYS:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Single-entry result register behind the ALU: latches result/destination,
// commits flags on accept and resolves branches against the committed flags.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_s,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_flag_en,
  input  logic              in_br_en,
  input  logic [2:0]        in_br_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_wen,
  output logic              out_br_taken,
  output logic [3:0]        flags_q
);

  logic              valid_r;
  logic [DATA_W-1:0] res_r;
  logic [RA_W-1:0]   rd_r;
  logic              wen_r;
  logic              br_taken_r;
  flags_t            flags_r;

  logic accept_s;
  logic drain_s;
  logic cond_taken_s;

  assign in_ready = ~valid_r | out_ready;
  assign accept_s = in_valid & in_ready & ~flush;
  assign drain_s  = valid_r & out_ready;

  // branch resolves on the flags committed before this edge's update
  br_cond_eval u_br_cond_eval (
    .flags (flags_r),
    .cond  (br_cond_t'(in_br_cond)),
    .taken (cond_taken_s)
  );

  // entry register, flag commit and handshake state
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= 1'b0;
      res_r      <= {DATA_W{1'b0}};
      rd_r       <= {RA_W{1'b0}};
      wen_r      <= 1'b0;
      br_taken_r <= 1'b0;
      flags_r    <= '0;
    end else if (flush) begin
      valid_r    <= 1'b0;
      wen_r      <= 1'b0;
      br_taken_r <= 1'b0;
    end else if (accept_s) begin
      valid_r    <= 1'b1;
      res_r      <= in_res;
      rd_r       <= in_rd;
      wen_r      <= in_wen & (in_op != CMP);
      br_taken_r <= in_br_en & cond_taken_s;
      if (in_flag_en) begin
        flags_r <= '{s: in_s, z: in_z, c: in_c, v: in_v};
      end else begin
        flags_r <= flags_r;
      end
    end else if (drain_s) begin
      valid_r    <= 1'b0;
      wen_r      <= 1'b0;
      br_taken_r <= 1'b0;
    end else begin
      valid_r    <= valid_r;
    end
  end

  assign out_valid    = valid_r;
  assign out_res      = res_r;
  assign out_rd       = rd_r;
  assign out_wen      = wen_r;
  assign out_br_taken = br_taken_r;
  assign flags_q      = flags_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a queue-based reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_res;
  logic        in_s, in_z, in_c, in_v;
  logic [2:0]  in_rd;
  logic        in_wen, in_flag_en, in_br_en;
  logic [2:0]  in_br_cond;
  logic        out_valid, out_ready;
  logic [15:0] out_res;
  logic [2:0]  out_rd;
  logic        out_wen, out_br_taken;
  logic [3:0]  flags_q;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  alu_result_stage #(.DATA_W(16), .RA_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_res(in_res),
    .in_s(in_s), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .in_rd(in_rd), .in_wen(in_wen), .in_flag_en(in_flag_en),
    .in_br_en(in_br_en), .in_br_cond(in_br_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wen(out_wen), .out_br_taken(out_br_taken),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        wen;
    logic        taken;
  } entry_t;

  entry_t     held[$];
  logic [3:0] m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // flags as {S,Z,C,V}
  function automatic logic cond_holds(input logic [2:0] code, input logic [3:0] f);
    logic s, z, v;
    s = f[3]; z = f[2]; v = f[0];
    if (code == 3'd0) return z;
    if (code == 3'd1) return s != v;
    if (code == 3'd2) return z || (s != v);
    if (code == 3'd3) return !z;
    if (code == 3'd4) return 1'b1;
    return 1'b0;
  endfunction

  // reference model advances on each edge from the inputs seen at that edge
  always @(posedge clk) begin
    entry_t e;
    bit ready;
    if (reset) begin
      held.delete();
      m_flags = 4'd0;
    end else if (flush) begin
      held.delete();
    end else begin
      ready = (held.size() == 0) || out_ready;
      if (held.size() != 0 && out_ready) void'(held.pop_front());
      if (in_valid && ready) begin
        e.res   = in_res;
        e.rd    = in_rd;
        e.wen   = in_wen && (in_op != 4'd5);
        e.taken = in_br_en && cond_holds(in_br_cond, m_flags);
        held.push_back(e);
        if (in_flag_en) m_flags = {in_s, in_z, in_c, in_v};
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", 32'(out_valid), 32'(held.size() != 0));
      chk("flags_q", 32'(flags_q), 32'(m_flags));
      chk("in_ready", 32'(in_ready), 32'((held.size() == 0) || out_ready));
      if (held.size() != 0) begin
        chk("out_res", 32'(out_res), 32'(held[0].res));
        chk("out_rd", 32'(out_rd), 32'(held[0].rd));
        chk("out_wen", 32'(out_wen), 32'(held[0].wen));
        chk("out_br_taken", 32'(out_br_taken), 32'(held[0].taken));
      end else begin
        chk("idle_wen", 32'(out_wen), 32'd0);
        chk("idle_taken", 32'(out_br_taken), 32'd0);
        chk("idle_res_known", 32'($isunknown({out_res, out_rd})), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_res = 16'd0;
    in_s = 1'b0; in_z = 1'b0; in_c = 1'b0; in_v = 1'b0;
    in_rd = 3'd0; in_wen = 1'b0; in_flag_en = 1'b0;
    in_br_en = 1'b0; in_br_cond = 3'd0;
  endtask

  task automatic branch(input logic [2:0] code);
    idle();
    in_valid = 1'b1; in_br_en = 1'b1; in_br_cond = code;
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checking = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_res", 32'(out_res), 32'd0);

    // 1: reset while an entry is held under back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_res = 16'hABCD; in_rd = 3'd5; in_wen = 1'b1;
    in_flag_en = 1'b1; in_s = 1'b1; in_z = 1'b1;
    tick();
    idle();
    chk("t1_held", 32'(out_valid), 32'd1);
    chk("t1_flags", 32'(flags_q), 32'hC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_res", 32'(out_res), 32'd0);
    chk("t1_rd", 32'(out_rd), 32'd0);
    chk("t1_wen", 32'(out_wen), 32'd0);
    chk("t1_flags0", 32'(flags_q), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // 2: four back-to-back ADDs at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_op = 4'd0; in_res = 16'(i); in_rd = 3'(i); in_wen = 1'b1;
      tick();
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_res", 32'(out_res), 32'(i));
    end
    idle();
    tick();
    chk("t2_drained", 32'(out_valid), 32'd0);

    // 3: back-pressure holds 16'h1234 and keeps the waiting entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_res = 16'h1234; in_rd = 3'd1; in_wen = 1'b1;
    tick();
    in_res = 16'h5678; in_rd = 3'd2;
    for (int i = 0; i < 3; i++) begin
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_res_hold", 32'(out_res), 32'h1234);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_next_res", 32'(out_res), 32'h5678);
    chk("t3_next_valid", 32'(out_valid), 32'd1);
    idle();
    tick();

    // 4: CMP commits flags without write-back, then branches see them
    in_valid = 1'b1; in_op = 4'd5; in_res = 16'h0007; in_rd = 3'd3;
    in_s = 1'b1; in_v = 1'b0; in_wen = 1'b1; in_flag_en = 1'b1;
    tick();
    chk("t4_cmp_wen", 32'(out_wen), 32'd0);
    chk("t4_flags", 32'(flags_q), 32'h8);
    branch(3'd1);
    tick();
    chk("t4_blt", 32'(out_br_taken), 32'd1);
    branch(3'd0);
    tick();
    chk("t4_be", 32'(out_br_taken), 32'd0);

    // 5: flush wins over a simultaneous flag-setting accept
    idle();
    flush = 1'b1; in_valid = 1'b1; in_flag_en = 1'b1; in_z = 1'b1; in_wen = 1'b1;
    tick();
    idle();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_flags", 32'(flags_q), 32'h8);

    // 6: SUB overflow flags, then BLE not taken
    in_valid = 1'b1; in_op = 4'd1; in_res = 16'h8000; in_s = 1'b1; in_v = 1'b1;
    in_flag_en = 1'b1; in_wen = 1'b1; in_rd = 3'd7;
    tick();
    chk("t6_flags", 32'(flags_q), 32'h9);
    chk("t6_res", 32'(out_res), 32'h8000);
    chk("t6_wen", 32'(out_wen), 32'd1);
    branch(3'd2);
    tick();
    chk("t6_ble", 32'(out_br_taken), 32'd0);
    branch(3'd3);
    tick();
    chk("bne", 32'(out_br_taken), 32'd1);
    branch(3'd4);
    tick();
    chk("always", 32'(out_br_taken), 32'd1);
    branch(3'd6);
    tick();
    chk("code6", 32'(out_br_taken), 32'd0);

    // branch that also sets flags resolves on the old flags
    branch(3'd0);
    in_flag_en = 1'b1; in_z = 1'b1;
    tick();
    chk("br_preflags", 32'(out_br_taken), 32'd0);
    chk("br_flags_upd", 32'(flags_q), 32'h4);
    branch(3'd0);
    tick();
    chk("be_after", 32'(out_br_taken), 32'd1);

    idle();
    tick(); tick();
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
